data_ram_ctrl: RTL

Parametrised data memory for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 32-word, ctrl-bit-decoded RAM with a request/response interface.
- Supports full MIPS load/store widths: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Detects misalignment.
- Registers load data with one-cycle latency.
- Runs a hardware clear sequence after reset.
- Keeps a combinational debug read port for the display board.

---
 rtl/data_ram_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_ram_ctrl.sv
// Byte-addressable CPU data memory with a request/response interface, MIPS load/store
// widths, misalignment detection, a post-reset clear sequence and a debug read port.
module data_ram_ctrl #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic [ADDR_W-3:0] test_addr,
  output logic [31:0]       test_data
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  widx;
  logic              accept, err_now;
  logic [3:0]        be;
  logic [31:0]       wlane;

  function automatic logic op_err(input logic [3:0] op, input logic [1:0] a);
    return (op[1:0] == 2'b11) || (op[3] && op[2]) ||
           (op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic uns,
                                           input logic [1:0] sz, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign req_ready  = (state_q == S_RUN);
  assign init_done  = (state_q == S_RUN);
  assign accept     = req_valid & req_ready;
  assign widx       = req_addr[ADDR_W-1:2];
  assign err_now    = op_err(req_op, req_addr[1:0]);
  assign be         = lane_en(req_op[1:0], req_addr[1:0]);
  assign wlane      = (req_op[1:0] == 2'b00) ? {4{req_wdata[7:0]}} :
                      (req_op[1:0] == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
  assign test_data  = mem_q[test_addr];
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    resp_valid_d = accept;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (state_q == S_INIT) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
    end
    if (accept) begin
      resp_err_d   = err_now;
      resp_rdata_d = (err_now || req_op[3]) ? 32'h0 :
                     load_ext(mem_q[widx], req_op[2], req_op[1:0], req_addr[1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The array has no reset; the clear sequence rewrites it word by word instead.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[idx_q] <= INIT_VAL;
    end else if (accept && req_op[3] && !err_now) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

endmodule
